// File: rtl/load_store_unit.sv
// Load/store unit: turns one RISC-V load/store into one or two word-aligned
// memory beats with byte strobes, merging and extending split load data.
module load_store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d, cross_q, cross_d, err_q, err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] beat1Addr_q, beat1Addr_d, beat1Wdata_q, beat1Wdata_d;
  logic [3:0]  beat1Strb_q, beat1Strb_d;
  logic        memReq_q, memReq_d, memWe_q, memWe_d;
  logic [31:0] memAddr_q, memAddr_d, memWdata_q, memWdata_d;
  logic [3:0]  memWstrb_q, memWstrb_d;

  logic [2:0]  reqSize, reqEnd, hiShift;
  logic [3:0]  reqOnes;
  logic        reqCross, reqLegalOp, reqLegal;
  logic [7:0]  reqMask;
  logic [63:0] reqWide;
  logic [31:0] beat0Addr, loadResult;

  // Both beats are derived at acceptance: the upper half of the 64-bit
  // shifted mask/data is exactly what spills into the next word.
  always_comb begin
    reqSize = 3'd4;
    reqOnes = 4'b1111;
    case (req_funct3_i[1:0])
      2'b00:   begin reqSize = 3'd1; reqOnes = 4'b0001; end
      2'b01:   begin reqSize = 3'd2; reqOnes = 4'b0011; end
      default: ;
    endcase
    reqEnd   = {1'b0, req_addr_i[1:0]} + reqSize;
    reqCross = reqEnd > 3'd4;
    if (req_we_i) reqLegalOp = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    else          reqLegalOp = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reqLegal  = reqLegalOp && (SPLIT_MISALIGNED || !reqCross);
    reqMask   = {4'b0000, reqOnes} << req_addr_i[1:0];
    reqWide   = {32'h0, req_wdata_i} << {req_addr_i[1:0], 3'b000};
    beat0Addr = {req_addr_i[31:2], 2'b00};
  end

  assign hiShift = 3'd4 - {1'b0, off_q};

  always_comb begin
    case (funct3_q)
      3'b000:  loadResult = {{24{rdata_q[7]}}, rdata_q[7:0]};
      3'b001:  loadResult = {{16{rdata_q[15]}}, rdata_q[15:0]};
      3'b100:  loadResult = {24'h0, rdata_q[7:0]};
      3'b101:  loadResult = {16'h0, rdata_q[15:0]};
      default: loadResult = rdata_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    cross_d      = cross_q;
    err_d        = err_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rdata_d      = rdata_q;
    beat1Addr_d  = beat1Addr_q;
    beat1Wdata_d = beat1Wdata_q;
    beat1Strb_d  = beat1Strb_q;
    memReq_d     = memReq_q;
    memWe_d      = memWe_q;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    memWstrb_d   = memWstrb_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d         = req_we_i;
          funct3_d     = req_funct3_i;
          off_d        = req_addr_i[1:0];
          cross_d      = reqCross;
          err_d        = !reqLegal;
          beat1Addr_d  = beat0Addr + 32'd4;
          beat1Wdata_d = reqWide[63:32];
          beat1Strb_d  = req_we_i ? reqMask[7:4] : 4'b0000;
          if (reqLegal) begin
            state_d    = REQ0;
            memReq_d   = 1'b1;
            memWe_d    = req_we_i;
            memAddr_d  = beat0Addr;
            memWstrb_d = req_we_i ? reqMask[3:0] : 4'b0000;
            memWdata_d = reqWide[31:0];
          end else begin
            state_d    = RESP;
          end
        end
      end
      REQ0: begin
        if (mem_gnt_i) begin
          memReq_d   = 1'b0;
          memWe_d    = 1'b0;
          memWstrb_d = 4'b0000;
          if (!we_q) begin
            state_d = WAIT0;
          end else if (cross_q) begin
            state_d    = REQ1;
            memReq_d   = 1'b1;
            memWe_d    = 1'b1;
            memAddr_d  = beat1Addr_q;
            memWstrb_d = beat1Strb_q;
            memWdata_d = beat1Wdata_q;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT0: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i >> {off_q, 3'b000};
          if (cross_q) begin
            state_d    = REQ1;
            memReq_d   = 1'b1;
            memAddr_d  = beat1Addr_q;
            memWdata_d = beat1Wdata_q;
          end else begin
            state_d = RESP;
          end
        end
      end
      REQ1: begin
        if (mem_gnt_i) begin
          memReq_d   = 1'b0;
          memWe_d    = 1'b0;
          memWstrb_d = 4'b0000;
          state_d    = we_q ? RESP : WAIT1;
        end
      end
      WAIT1: begin
        if (mem_rvalid_i) begin
          rdata_d = rdata_q | (mem_rdata_i << {hiShift, 3'b000});
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      cross_q      <= 1'b0;
      err_q        <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      rdata_q      <= 32'h0;
      beat1Addr_q  <= 32'h0;
      beat1Wdata_q <= 32'h0;
      beat1Strb_q  <= 4'b0000;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= 32'h0;
      memWdata_q   <= 32'h0;
      memWstrb_q   <= 4'b0000;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      cross_q      <= cross_d;
      err_q        <= err_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rdata_q      <= rdata_d;
      beat1Addr_q  <= beat1Addr_d;
      beat1Wdata_q <= beat1Wdata_d;
      beat1Strb_q  <= beat1Strb_d;
      memReq_q     <= memReq_d;
      memWe_q      <= memWe_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      memWstrb_q   <= memWstrb_d;
    end
  end

  assign req_ready_o  = state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = (resp_valid_o && !err_q && !we_q) ? loadResult : 32'h0;
  assign mem_req_o    = memReq_q;
  assign mem_we_o     = memWe_q;
  assign mem_addr_o   = memAddr_q;
  assign mem_wstrb_o  = memWstrb_q;
  assign mem_wdata_o  = memWdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a byte-level reference model predicts
// every memory beat and load result; a responder models the data memory.
module tb_load_store_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0, reqWe = 1'b0;
  logic [2:0]  reqFunct3 = 3'b000;
  logic [31:0] reqAddr = 32'h0, reqWdata = 32'h0;
  logic        reqReady, respValid, respErr, memReq, memWe;
  logic [31:0] respRdata, memAddr, memWdata;
  logic [3:0]  memWstrb;
  logic        memGnt, memRvalid;
  logic [31:0] memRdata;

  logic        nsReqValid = 1'b0, nsReqWe = 1'b0;
  logic [2:0]  nsReqFunct3 = 3'b000;
  logic [31:0] nsReqAddr = 32'h0, nsReqWdata = 32'h0;
  logic        nsReqReady, nsRespValid, nsRespErr, nsMemReq, nsMemWe;
  logic [31:0] nsRespRdata, nsMemAddr, nsMemWdata;
  logic [3:0]  nsMemWstrb;

  beat_t       beatQ[$];
  logic [31:0] memWords [logic [31:0]];
  int          nChecks = 0, nFails = 0;
  int          gntMode = 1, rdMax = 0, rdCount = 0;
  bit          rdPending = 1'b0;
  logic [31:0] rdAddr = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
    .req_funct3_i(reqFunct3), .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
    .resp_valid_o(respValid), .resp_rdata_o(respRdata), .resp_err_o(respErr),
    .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
    .mem_wstrb_o(memWstrb), .mem_wdata_o(memWdata),
    .mem_gnt_i(memGnt), .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata)
  );

  load_store_unit #(.SPLIT_MISALIGNED(1'b0)) u_dut_nosplit (
    .clk(clk), .rst(rst),
    .req_valid_i(nsReqValid), .req_ready_o(nsReqReady), .req_we_i(nsReqWe),
    .req_funct3_i(nsReqFunct3), .req_addr_i(nsReqAddr), .req_wdata_i(nsReqWdata),
    .resp_valid_o(nsRespValid), .resp_rdata_o(nsRespRdata), .resp_err_o(nsRespErr),
    .mem_req_o(nsMemReq), .mem_we_o(nsMemWe), .mem_addr_o(nsMemAddr),
    .mem_wstrb_o(nsMemWstrb), .mem_wdata_o(nsMemWdata),
    .mem_gnt_i(1'b1), .mem_rvalid_i(1'b0), .mem_rdata_i(32'h0)
  );

  function automatic logic [31:0] memRead(input logic [31:0] wa);
    if (memWords.exists(wa)) return memWords[wa];
    return {wa[15:0], ~wa[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] laneMask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: random or forced grants, read data 1+rdMax cycles after the
  // grant, and a check that a stalled beat keeps its address/strobes/data.
  initial begin : memResponder
    bit          stalled;
    logic [31:0] prevAddr, prevData;
    logic [3:0]  prevStrb;
    beat_t       b;
    stalled = 1'b0; prevAddr = 32'h0; prevData = 32'h0; prevStrb = 4'h0;
    memGnt = 1'b0; memRvalid = 1'b0; memRdata = 32'h0;
    forever begin
      @(negedge clk);
      memRvalid = 1'b0;
      if (rdPending) begin
        if (rdCount == 0) begin
          memRvalid = 1'b1;
          memRdata  = memRead(rdAddr);
          rdPending = 1'b0;
        end else begin
          rdCount--;
        end
      end
      if (memReq && stalled) begin
        checkOutput("stall_addr", memAddr, prevAddr);
        checkOutput("stall_strb", {28'h0, memWstrb}, {28'h0, prevStrb});
        checkOutput("stall_wdata", memWdata, prevData);
      end
      case (gntMode)
        1:       memGnt = 1'b1;
        2:       memGnt = 1'b0;
        default: memGnt = ($urandom_range(0, 2) != 0);
      endcase
      if (memReq && memGnt) begin
        b.addr = memAddr; b.we = memWe; b.strb = memWstrb; b.data = memWdata;
        beatQ.push_back(b);
        if (!memWe) begin
          rdPending = 1'b1;
          rdCount   = $urandom_range(0, rdMax);
          rdAddr    = memAddr;
        end
      end
      stalled  = memReq && !memGnt;
      prevAddr = memAddr; prevStrb = memWstrb; prevData = memWdata;
    end
  end

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    rdPending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issueRequest(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
    @(negedge clk);
    checkOutput("ready_idle", {31'h0, reqReady}, 32'h1);
    checkOutput("resp_one_pulse", {31'h0, respValid}, 32'h0);
    beatQ.delete();
    reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = a; reqWdata = wd;
    @(posedge clk);
    #1 reqValid = 1'b0;
  endtask

  task automatic waitResponse(output int lat, output bit timedOut);
    lat = 1;
    @(negedge clk);
    while (!respValid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    timedOut = !respValid;
  endtask

  // Reference: walk the accessed bytes one at a time and group them by word.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int expLat,
                               output logic [31:0] gotRdata);
    int          size, nE, lat;
    bit          legal, timedOut;
    logic [31:0] eAddr[2], eData[2];
    logic [3:0]  eStrb[2];
    logic [31:0] result, ba, wa, w;
    logic [1:0]  lane;
    size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nE     = 0;
    result = 32'h0;
    if (legal) begin
      for (int i = 0; i < size; i++) begin
        ba   = a + 32'(i);
        wa   = {ba[31:2], 2'b00};
        lane = ba[1:0];
        if (nE == 0 || eAddr[nE-1] != wa) begin
          eAddr[nE] = wa; eStrb[nE] = 4'h0; eData[nE] = 32'h0;
          nE++;
        end
        if (we) begin
          eStrb[nE-1][lane]          = 1'b1;
          eData[nE-1][8*lane +: 8]   = wd[8*i +: 8];
        end else begin
          w                = memRead(wa) >> (8 * lane);
          result[8*i +: 8] = w[7:0];
        end
      end
      if (!we && f3 == 3'd0) result = {{24{result[7]}}, result[7:0]};
      if (!we && f3 == 3'd1) result = {{16{result[15]}}, result[15:0]};
    end
    if (we || !legal) result = 32'h0;

    issueRequest(we, f3, a, wd);
    waitResponse(lat, timedOut);
    gotRdata = respRdata;
    if (timedOut) begin
      checkOutput("resp_timeout", 32'h0, 32'h1);
      pulseReset();
      return;
    end
    checkOutput("resp_err", {31'h0, respErr}, {31'h0, !legal});
    checkOutput("resp_rdata", respRdata, result);
    checkOutput("req_in_resp", {31'h0, memReq}, 32'h0);
    if (expLat >= 0) checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("beat_count", 32'(beatQ.size()), 32'(nE));
    for (int i = 0; i < nE && i < beatQ.size(); i++) begin
      checkOutput("beat_addr", beatQ[i].addr, eAddr[i]);
      checkOutput("beat_we", {31'h0, beatQ[i].we}, {31'h0, we});
      checkOutput("beat_strb", {28'h0, beatQ[i].strb}, {28'h0, eStrb[i]});
      checkOutput("beat_wdata", beatQ[i].data & laneMask(eStrb[i]), eData[i]);
    end
  endtask

  task automatic nsRequest(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output bit sawReq,
                           output logic [31:0] firstAddr, output logic [3:0] firstStrb);
    @(negedge clk);
    nsReqValid = 1'b1; nsReqWe = we; nsReqFunct3 = f3; nsReqAddr = a; nsReqWdata = wd;
    @(posedge clk);
    #1 nsReqValid = 1'b0;
    lat = 1; sawReq = 1'b0; firstAddr = 32'h0; firstStrb = 4'h0;
    @(negedge clk);
    while (!nsRespValid && lat < 20) begin
      if (nsMemReq && !sawReq) begin
        sawReq = 1'b1; firstAddr = nsMemAddr; firstStrb = nsMemWstrb;
        checkOutput("ns_we", {31'h0, nsMemWe}, {31'h0, we});
        checkOutput("ns_wdata", nsMemWdata, wd);
      end
      @(negedge clk);
      lat++;
    end
    checkOutput("ns_resp_seen", {31'h0, nsRespValid}, 32'h1);
    checkOutput("ns_rdata", nsRespRdata, 32'h0);
  endtask

  initial begin : mainSeq
    logic [31:0] r, nsAddr;
    logic [3:0]  nsStrb;
    int          lat;
    bit          saw;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_ready", {31'h0, reqReady}, 32'h1);
    checkOutput("rst_resp_valid", {31'h0, respValid}, 32'h0);
    checkOutput("rst_resp_err", {31'h0, respErr}, 32'h0);
    checkOutput("rst_resp_rdata", respRdata, 32'h0);
    checkOutput("rst_mem_req", {31'h0, memReq}, 32'h0);
    checkOutput("rst_mem_we", {31'h0, memWe}, 32'h0);
    checkOutput("rst_mem_wstrb", {28'h0, memWstrb}, 32'h0);
    checkOutput("rst_mem_addr", memAddr, 32'h0);
    checkOutput("rst_mem_wdata", memWdata, 32'h0);

    $display("[TB] directed accesses");
    gntMode = 1; rdMax = 0;
    memWords[32'h100] = 32'hDEADBEEF;
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 3, r);
    checkOutput("lw_aligned_const", r, 32'hDEADBEEF);
    memWords[32'h100] = 32'h80112233;
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 3, r);
    checkOutput("lb_sign_const", r, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 3, r);
    checkOutput("lbu_zero_const", r, 32'h00000080);
    applyStimulus(1'b1, 3'b001, 32'h203, 32'h0000ABCD, 3, r);
    memWords[32'h300] = 32'h11223344;
    memWords[32'h304] = 32'h55667788;
    applyStimulus(1'b0, 3'b010, 32'h302, 32'h0, 5, r);
    checkOutput("lw_split_const", r, 32'h77881122);
    applyStimulus(1'b1, 3'b010, 32'hFFFFFFFD, 32'h11223344, 3, r);
    applyStimulus(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 2, r);
    applyStimulus(1'b0, 3'b101, 32'h302, 32'h0, 3, r);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 1, r);
    applyStimulus(1'b1, 3'b100, 32'h100, 32'h1234, 1, r);

    $display("[TB] no-split instance");
    nsRequest(1'b0, 3'b001, 32'h103, 32'h0, lat, saw, nsAddr, nsStrb);
    checkOutput("ns_mis_err", {31'h0, nsRespErr}, 32'h1);
    checkOutput("ns_mis_lat", 32'(lat), 32'd1);
    checkOutput("ns_mis_noreq", {31'h0, saw}, 32'h0);
    nsRequest(1'b1, 3'b010, 32'h10, 32'h89ABCDEF, lat, saw, nsAddr, nsStrb);
    checkOutput("ns_sw_err", {31'h0, nsRespErr}, 32'h0);
    checkOutput("ns_sw_lat", 32'(lat), 32'd2);
    checkOutput("ns_sw_req", {31'h0, saw}, 32'h1);
    checkOutput("ns_sw_addr", nsAddr, 32'h10);
    checkOutput("ns_sw_strb", {28'h0, nsStrb}, 32'hF);

    $display("[TB] reset mid-operation");
    gntMode = 2;
    issueRequest(1'b0, 3'b010, 32'h400, 32'h0);
    @(negedge clk);
    checkOutput("rst_stall_req", {31'h0, memReq}, 32'h1);
    #1 rst = 1'b1;
    rdPending = 1'b0;
    #1;
    checkOutput("rst_async_req", {31'h0, memReq}, 32'h0);
    checkOutput("rst_async_ready", {31'h0, reqReady}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    gntMode = 1; rdMax = 0;
    issueRequest(1'b0, 3'b010, 32'h500, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    rdPending = 1'b0;
    #1;
    checkOutput("rst_wait0_req", {31'h0, memReq}, 32'h0);
    checkOutput("rst_wait0_ready", {31'h0, reqReady}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h600, 32'h0, 3, r);

    $display("[TB] randomized accesses");
    gntMode = 0; rdMax = 2;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else                           a = 32'($urandom_range(0, 4095));
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, -1, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory interface: accepts one load or store per request from the execute stage and translates RISC-V funct3 into word-aligned memory beats with byte strobes. A naturally aligned access takes one beat. An access that crosses a 4-byte boundary is split into two beats; for loads the two read words are merged and zero- or sign-extended. Sits between the EX/MEM stage and the byte-addressed data memory; the pipeline stalls while `req_ready` is low.

## Interface
- `SPLIT_MISALIGNED`, default 1: 1 = split boundary-crossing accesses into two beats; 0 = reject them with `resp_err`, no memory beat issued.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, LSB-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load result; 0 for stores and errors.
- `resp_err` output 1: valid with `resp_valid`; high for an illegal funct3, or a misaligned access when `SPLIT_MISALIGNED`=0.
- `mem_req` output 1: beat request, held until granted.
- `mem_we` output 1: beat is a write.
- `mem_addr` output 32: word address, bits [1:0] always 0.
- `mem_wstrb` output 4: byte enables, bit i selects byte lane i; 0000 on reads.
- `mem_wdata` output 32: lane-aligned write data.
- `mem_gnt` input 1: beat accepted on the edge where `mem_req && mem_gnt`.
- `mem_rvalid` input 1: read data valid; arrives one or more cycles after the grant.
- `mem_rdata` input 32: read word.

## Operation
- States and transitions:
  - IDLE: wait for an accepted request.
  - REQ0: issue the first beat; go to WAIT0 (read) or the next state (write) on grant.
  - WAIT0: wait for `mem_rvalid`.
  - REQ1: issue the second beat.
  - WAIT1: wait for `mem_rvalid`.
  - RESP: pulse `resp_valid` for one cycle, then IDLE.
- Request capture: on acceptance, latch `we`, `funct3`, `addr` and `wdata`.
  - Legal request: go to REQ0.
  - Illegal request: go directly to RESP with `resp_err`=1.
- Access size and offset:
  - Size: 1, 2 or 4 bytes from funct3.
  - off = `addr[1:0]`.
  - Crossing = off + size > 4.
- Beat 0:
  - `mem_addr` = `addr & ~3`.
  - Strobes cover bytes off .. min(off+size-1, 3).
  - `mem_wdata` = `wdata << 8*off`.
- Beat 1, crossing accesses only:
  - `mem_addr` = beat-0 address + 4, computed modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - Strobes cover the remaining (off+size-4) low lanes.
  - `mem_wdata` = `wdata >> 8*(4-off)`.
- Write sequencing: after the final beat's grant go to RESP; `mem_rvalid` is not awaited.
- Read sequencing:
  - After a beat's grant go to its WAIT state.
  - Beat-0 data is captured as `rdata0 >> 8*off`.
  - Beat-1 data is OR-merged as `rdata1 << 8*(4-off)`.
- Load result: mask to size, then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW is passed unchanged.
- Outputs outside REQ0/REQ1: `mem_req`=0, `mem_we`=0, `mem_wstrb`=0000, `mem_addr`/`mem_wdata` hold their last values.
- `mem_rvalid` outside the WAIT states is ignored.

## Timing
- Reset values (asynchronous): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
- Memory-side outputs are registered.
- Reset mid-operation: `mem_req` drops immediately and any outstanding read response is discarded.
- Acceptance at edge 0: `mem_req` is high during cycle 1.
- Aligned load, with grant in cycle 1 and `mem_rvalid` in cycle 2: `resp_valid` in cycle 3.
- Aligned store, with grant in cycle 1: `resp_valid` in cycle 2.
- Split access: REQ1 follows WAIT0 (load) or the beat-0 grant (store) with no idle cycle.
- Best-case latency: split load 5 cycles, split store 3 cycles.
- Illegal request: `resp_valid`+`resp_err` in cycle 1; no `mem_req` is issued.
- `mem_gnt` low stalls in REQx indefinitely, with `mem_addr`, `mem_wstrb` and `mem_wdata` stable.
- `req_ready` returns to 1 in the cycle after RESP; back-to-back requests therefore have one RESP cycle between them.

## Test plan
- Aligned LW at 0x100; memory returns 0xDEADBEEF, grant immediate, rvalid 1 cycle later -> one beat addr 0x100, strb 0000; `resp_rdata`=0xDEADBEEF in cycle 3.
- LB at 0x103 with word 0x80112233 -> `resp_rdata`=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x203 of 0xABCD -> two beats:
  - Beat 0: addr 0x200, strb 1000, wdata[31:24]=0xCD.
  - Beat 1: addr 0x204, strb 0001, wdata[7:0]=0xAB.
  - `resp_valid` after the second grant.
- LW at 0x302; words 0x11223344 at 0x300 and 0x55667788 at 0x304 -> `resp_rdata`=0x77881122.
- SW at 0xFFFFFFFD -> beat 0 addr 0xFFFFFFFC strb 1110; beat 1 addr 0x00000000 strb 0001.
- Error and reset cases:
  - Load with funct3=011 -> `resp_err`=1 in cycle 1, no `mem_req`.
  - Misaligned LH with `SPLIT_MISALIGNED`=0 -> `resp_err`=1, no `mem_req`.
  - `rst` pulsed during WAIT0 -> `mem_req` 0 immediately, `req_ready` 1; the next request completes normally.
